// File: rtl/sdram_port_arbiter_if.sv
`timescale 1ns/1ps
// Bundle of requester and SDRAM-controller handshake signals for sdram_port_arbiter.
// Modport master is the arbiter's view; modport slave is the requesters' and controller's view.
interface sdram_port_arbiter_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 16
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_ack;
   logic [DATA_W-1:0] a_rdata;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_ack;
   logic [DATA_W-1:0] b_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_busy;

   logic              grant_b;
   logic              err;

   modport master (
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      input  mem_ack, mem_rdata, mem_busy,
      output a_ack, a_rdata, b_ack, b_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output grant_b, err
   );

   modport slave (
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      output mem_ack, mem_rdata, mem_busy,
      input  a_ack, a_rdata, b_ack, b_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  grant_b, err
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one SDRAM controller word port between requesters A and B.
// Define SDRAM_ARB_TIMEOUT_EN to abort transactions the controller never acknowledges.
module sdram_port_arbiter #(
   parameter int ADDR_W  = 24,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   sdram_port_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t              state_q,     state_d;
   logic                mem_req_q,   mem_req_d;
   logic                mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                a_ack_q,     a_ack_d;
   logic                b_ack_q,     b_ack_d;
   logic [DATA_W-1:0]   a_rdata_q,   a_rdata_d;
   logic [DATA_W-1:0]   b_rdata_q,   b_rdata_d;
   logic                last_b_q,    last_b_d;
   logic                grant_b_q,   grant_b_d;
   logic                take_b;
   logic                finish;
   logic [DATA_W-1:0]   ret_data;

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("TIMEOUT must be at least 1");
   end

`ifdef SDRAM_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
`endif

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      a_ack_d     = 1'b0;
      b_ack_d     = 1'b0;
      a_rdata_d   = a_rdata_q;
      b_rdata_d   = b_rdata_q;
      last_b_d    = last_b_q;
      grant_b_d   = grant_b_q;
      take_b      = 1'b0;
      finish      = 1'b0;
      ret_data    = bus.mem_rdata;
`ifdef SDRAM_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = err_q;
`endif

      case (state_q)
         IDLE: begin
            if (!bus.mem_busy && (bus.a_req || bus.b_req)) begin
               // Under contention the port not served last time wins.
               take_b      = bus.b_req && (!bus.a_req || !last_b_q);
               mem_we_d    = take_b ? bus.b_we    : bus.a_we;
               mem_addr_d  = take_b ? bus.b_addr  : bus.a_addr;
               mem_wdata_d = take_b ? bus.b_wdata : bus.a_wdata;
               mem_req_d   = 1'b1;
               last_b_d    = take_b;
               grant_b_d   = take_b;
               state_d     = ISSUE;
`ifdef SDRAM_ARB_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         ISSUE: begin
            if (bus.mem_ack) begin
               finish = 1'b1;
            end
`ifdef SDRAM_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               finish   = 1'b1;
               ret_data = '1;
               err_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Completion is routed by the latched grant, never by the live req lines.
      if (finish) begin
         mem_req_d = 1'b0;
         state_d   = DONE;
         if (last_b_q) begin
            b_ack_d = 1'b1;
            if (!mem_we_q) b_rdata_d = ret_data;
         end else begin
            a_ack_d = 1'b1;
            if (!mem_we_q) a_rdata_d = ret_data;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         a_ack_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
         last_b_q    <= 1'b1;
         grant_b_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         a_ack_q     <= a_ack_d;
         b_ack_q     <= b_ack_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
         last_b_q    <= last_b_d;
         grant_b_q   <= grant_b_d;
      end
   end

`ifdef SDRAM_ARB_TIMEOUT_EN
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.a_ack     = a_ack_q;
   assign bus.b_ack     = b_ack_q;
   assign bus.a_rdata   = a_rdata_q;
   assign bus.b_rdata   = b_rdata_q;
   assign bus.grant_b   = grant_b_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for sdram_port_arbiter: random requesters, a controller model and a
// transaction-level arbitration model; SDRAM_ARB_TIMEOUT_EN enables the timeout scenario.
module tb_sdram_port_arbiter;
   localparam int AW  = 24;
   localparam int DW  = 16;
   localparam int TMO = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;

   sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

   sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (ifc.master)
   );

   always #10 clk = ~clk;

   typedef struct {
      bit            port;
      bit            we;
      logic [DW-1:0] rdata;
   } exp_t;

   int checks = 0;
   int errors = 0;

   exp_t          exp_q[$];
   int            grant_log[$];
   bit            d_we[2];
   logic [AW-1:0] d_addr[2];
   logic [DW-1:0] d_wd[2];
   logic [DW-1:0] rd_m[2];
   bit            last_b_m;
   bit            cur_port;
   bit            cur_we;
   bit            prev_req;
   logic [AW-1:0] snap_addr;
   logic [DW-1:0] snap_wd;
   bit            snap_we;

   bit            resp_en   = 1'b1;
   bit            rand_busy = 1'b0;
   bit            force_en  = 1'b0;
   logic [DW-1:0] force_rd  = '0;
   int            lat_min   = 1;
   int            lat_max   = 1;
   bit            pending   = 1'b0;
   int            wcnt      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // One requester transaction: raise req with a fresh descriptor, wait for ack, drop req.
   task automatic txn(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      int n;
      @(negedge clk);
      d_we[p] = we; d_addr[p] = a; d_wd[p] = wd;
      if (p) begin
         ifc.b_we = we; ifc.b_addr = a; ifc.b_wdata = wd; ifc.b_req = 1'b1;
      end else begin
         ifc.a_we = we; ifc.a_addr = a; ifc.a_wdata = wd; ifc.a_req = 1'b1;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(p ? ifc.b_ack : ifc.a_ack) && n < 400);
      chk(p ? "txn_done_b" : "txn_done_a", 32'(n < 400), 1);
      if (p) ifc.b_req = 1'b0;
      else   ifc.a_req = 1'b0;
   endtask

   // Controller model: acknowledge each request after a random latency.
   initial begin
      ifc.mem_ack   = 1'b0;
      ifc.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (resp_en) begin
            ifc.mem_ack = 1'b0;
            if (ifc.mem_req && !pending && !rst) begin
               pending = 1'b1;
               wcnt    = $urandom_range(lat_max, lat_min);
            end
            if (pending) begin
               if (wcnt <= 1) begin
                  ifc.mem_ack   = 1'b1;
                  ifc.mem_rdata = force_en ? force_rd : DW'($urandom);
                  pending       = 1'b0;
                  exp_q.push_back('{cur_port, cur_we, ifc.mem_rdata});
               end else begin
                  wcnt--;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rand_busy) ifc.mem_busy = ($urandom_range(0, 4) == 0);
      end
   end

   // Monitor: arbitration rule at each new grant, stability during issue, acks against scoreboard.
   initial begin
      exp_t e;
      bit   ra, rb, w;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            prev_req = 1'b0;
            last_b_m = 1'b1;
            rd_m[0]  = '0;
            rd_m[1]  = '0;
            exp_q.delete();
         end else begin
            if (ifc.a_ack || ifc.b_ack) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_ack", {30'd0, ifc.a_ack, ifc.b_ack}, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("ack_port", {30'd0, ifc.a_ack, ifc.b_ack}, e.port ? 2'b01 : 2'b10);
                  if (!e.we) rd_m[e.port] = e.rdata;
                  chk("a_rdata", ifc.a_rdata, rd_m[0]);
                  chk("b_rdata", ifc.b_rdata, rd_m[1]);
               end
            end
            if (ifc.mem_req && !prev_req) begin
               ra = ifc.a_req;
               rb = ifc.b_req;
               chk("grant_has_req", 32'(ra | rb), 1);
               chk("grant_while_busy", ifc.mem_busy, 0);
               w = (ra && rb) ? !last_b_m : rb;
               chk("grant_b", ifc.grant_b, w);
               chk("mem_we", ifc.mem_we, d_we[w]);
               chk("mem_addr", ifc.mem_addr, d_addr[w]);
               chk("mem_wdata", ifc.mem_wdata, d_wd[w]);
               last_b_m  = w;
               cur_port  = w;
               cur_we    = d_we[w];
               snap_addr = ifc.mem_addr;
               snap_wd   = ifc.mem_wdata;
               snap_we   = ifc.mem_we;
               grant_log.push_back(int'(w));
            end else if (ifc.mem_req) begin
               chk("issue_stable", {ifc.mem_we, ifc.mem_wdata}, {snap_we, snap_wd});
               chk("issue_addr_stable", ifc.mem_addr, snap_addr);
            end
            prev_req = ifc.mem_req;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int len;
      ifc.a_req = 0; ifc.a_we = 0; ifc.a_addr = '0; ifc.a_wdata = '0;
      ifc.b_req = 0; ifc.b_we = 0; ifc.b_addr = '0; ifc.b_wdata = '0;
      ifc.mem_busy = 0;

      #1 rst = 1'b1;
      #2;
      chk("rst_mem_req", ifc.mem_req, 0);
      chk("rst_mem_we", ifc.mem_we, 0);
      chk("rst_mem_addr", ifc.mem_addr, 0);
      chk("rst_mem_wdata", ifc.mem_wdata, 0);
      chk("rst_acks", {ifc.a_ack, ifc.b_ack}, 0);
      chk("rst_rdata", {ifc.a_rdata, ifc.b_rdata}, 0);
      chk("rst_grant_b", ifc.grant_b, 0);
      chk("rst_err", ifc.err, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Port A write, controller latency 5, grant one cycle after req.
      lat_min = 5; lat_max = 5;
      fork txn(1'b0, 1'b1, 24'h000010, 16'h1234); join_none
      @(negedge clk);
      @(posedge clk); #1;
      chk("grant_latency", ifc.mem_req, 1);
      chk("write_addr", ifc.mem_addr, 24'h000010);
      chk("write_data", ifc.mem_wdata, 16'h1234);
      wait fork;

      // Port B read returning a fixed word.
      force_en = 1'b1; force_rd = 16'hBEEF; lat_min = 2; lat_max = 2;
      txn(1'b1, 1'b0, 24'h0ABCDE, 16'h0000);
      force_en = 1'b0;
      @(posedge clk); #1;
      chk("b_read_data", ifc.b_rdata, 16'hBEEF);
      chk("a_rdata_kept", ifc.a_rdata, 16'h0000);

      // Contention with immediate re-request.
      lat_min = 1; lat_max = 3;
      grant_log.delete();
      fork
         repeat (2) txn(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
         repeat (2) txn(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      join
      chk("contention_count", grant_log.size(), 4);
      if (grant_log.size() == 4)
         chk("contention_order", {grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}, 4'b0101);

      // Refresh hold, then busy raised mid-issue.
      @(negedge clk) ifc.mem_busy = 1'b1;
      lat_min = 6; lat_max = 6;
      fork txn(1'b0, 1'b1, 24'h000200, 16'h5A5A); join_none
      n = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (ifc.mem_req) n++;
      end
      chk("busy_hold_req_cycles", n, 0);
      @(negedge clk) ifc.mem_busy = 1'b0;
      @(posedge clk); #1;
      chk("busy_release_grant", ifc.mem_req, 1);
      @(negedge clk) ifc.mem_busy = 1'b1;
      wait fork;
      @(negedge clk) ifc.mem_busy = 1'b0;

      // Stray controller ack while idle.
      resp_en = 1'b0;
      @(negedge clk) ifc.mem_ack = 1'b1;
      @(negedge clk) ifc.mem_ack = 1'b0;
      @(posedge clk); #1;
      chk("idle_ack_ignored", {ifc.mem_req, ifc.a_ack, ifc.b_ack}, 0);

      // Reset in the middle of an issue.
      @(negedge clk);
      d_we[0] = 1'b1; d_addr[0] = 24'h00F00D; d_wd[0] = 16'hCAFE;
      ifc.a_we = 1'b1; ifc.a_addr = 24'h00F00D; ifc.a_wdata = 16'hCAFE; ifc.a_req = 1'b1;
      @(posedge clk); #1;
      chk("pre_reset_req", ifc.mem_req, 1);
      #3 rst = 1'b1;
      #1;
      chk("midrst_mem_req", ifc.mem_req, 0);
      chk("midrst_mem_bus", {ifc.mem_we, ifc.mem_addr, ifc.mem_wdata}, 0);
      chk("midrst_acks", {ifc.a_ack, ifc.b_ack}, 0);
      @(negedge clk) ifc.a_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      resp_en = 1'b1; lat_min = 1; lat_max = 4;
      grant_log.delete();
      fork
         txn(1'b0, 1'b0, AW'($urandom), DW'($urandom));
         txn(1'b1, 1'b0, AW'($urandom), DW'($urandom));
      join
      chk("post_reset_count", grant_log.size(), 2);
      if (grant_log.size() == 2)
         chk("post_reset_order", {grant_log[0][0], grant_log[1][0]}, 2'b01);

`ifdef SDRAM_ARB_TIMEOUT_EN
      // Controller never answers: the arbiter aborts after TMO issue cycles.
      resp_en = 1'b0;
      exp_q.push_back('{1'b0, 1'b0, 16'hFFFF});
      fork txn(1'b0, 1'b0, 24'h000777, 16'h0000); join_none
      n = 0;
      while (!ifc.mem_req && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      len = 0;
      while (ifc.mem_req && len < 100) begin
         @(posedge clk); #1;
         len++;
      end
      chk("timeout_len", len, TMO);
      wait fork;
      chk("timeout_rdata", ifc.a_rdata, 16'hFFFF);
      repeat (5) @(posedge clk);
      #1;
      chk("timeout_err_sticky", ifc.err, 1);
      #3 rst = 1'b1;
      #1;
      chk("timeout_err_reset", ifc.err, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      resp_en = 1'b1;
`else
      len = 0;
`endif

      // Randomised traffic with random refresh windows.
      lat_min = 1; lat_max = 6;
      rand_busy = 1'b1;
      fork
         for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            txn(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
         end
         for (int j = 0; j < 25; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            txn(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
         end
      join
      rand_busy = 1'b0;
      @(negedge clk) ifc.mem_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("final_mem_req", ifc.mem_req, 0);
`ifndef SDRAM_ARB_TIMEOUT_EN
      chk("err_tied_low", ifc.err, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
